// File: rtl/display_scan_controller_if.sv
// Display scan controller bundle: mode/frame inputs toward the scanner, scan outputs back.
// Combinational wires only; no flow control.
interface display_scan_controller_if #(
    parameter int SEGMENT_NUM = 4
);
    localparam int IDX_W   = (SEGMENT_NUM > 2) ? $clog2(SEGMENT_NUM) : 1;
    localparam int FIELD_W = (SEGMENT_NUM > 2) ? $clog2(SEGMENT_NUM / 2) : 1;

    logic [1:0]               mode;
    logic [FIELD_W-1:0]       edit_field;
    logic                     alarm_active;
    logic [4*SEGMENT_NUM-1:0] time_bcd;
    logic [4*SEGMENT_NUM-1:0] alarm_bcd;
    logic                     refresh_tick;
    logic [IDX_W-1:0]         digit_idx;
    logic [3:0]               bcd_digit;
    logic [SEGMENT_NUM-1:0]   anodes;

    modport master (
        output mode, edit_field, alarm_active, time_bcd, alarm_bcd,
        input  refresh_tick, digit_idx, bcd_digit, anodes
    );

    modport slave (
        input  mode, edit_field, alarm_active, time_bcd, alarm_bcd,
        output refresh_tick, digit_idx, bcd_digit, anodes
    );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan: refresh prescaler, per-frame source snapshot, edit/ringing blink.
// Outputs registered 1 clk after each refresh tick; no backpressure (free-running scan).
module display_scan_controller #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int BLINK_HZ    = 2,
    parameter int SEGMENT_NUM = 4
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    display_scan_controller_if.slave  bus
);
    localparam int DIV       = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int BLINK_DIV = REFRESH_HZ / (2 * BLINK_HZ);
    localparam int PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W     = (SEGMENT_NUM > 2) ? $clog2(SEGMENT_NUM) : 1;
    localparam int FRAME_W   = 4 * SEGMENT_NUM;

    typedef enum logic [2:0] {
        SHOW_TIME,
        SHOW_ALARM,
        EDIT_TIME,
        EDIT_ALARM,
        RINGING
    } state_t;

    state_t                   state_q, state_d;
    logic [PRE_W-1:0]         pre_cnt;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BLK_W-1:0]         blink_q, blink_d;
    logic                     phase_q, phase_d;
    logic [FRAME_W-1:0]       frame_q, frame_d;
    logic [3:0]               bcd_q, bcd_d;
    logic [SEGMENT_NUM-1:0]   anodes_q, anodes_d;
    logic                     tick;
    logic                     frame_end;
    logic                     blank;
    logic [IDX_W-1:0]         field_of_idx;

    assign tick      = (pre_cnt == PRE_W'(DIV - 1));
    assign frame_end = tick && (idx_q == IDX_W'(SEGMENT_NUM - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        blink_d      = blink_q;
        phase_d      = phase_q;
        frame_d      = frame_q;
        blank        = 1'b0;
        field_of_idx = '0;

        if (tick) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
            if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        // Mode is only honoured at frame boundaries so a frame never mixes sources.
        if (frame_end) begin
            if (bus.alarm_active) begin
                state_d = RINGING;
            end else begin
                case (bus.mode)
                    2'b00:   state_d = SHOW_TIME;
                    2'b01:   state_d = SHOW_ALARM;
                    2'b10:   state_d = EDIT_TIME;
                    default: state_d = EDIT_ALARM;
                endcase
            end
            frame_d = (state_d == SHOW_ALARM || state_d == EDIT_ALARM) ? bus.alarm_bcd
                                                                       : bus.time_bcd;
        end

        // Blanking looks at the post-tick state, phase and index.
        field_of_idx = idx_d >> 1;
        if (phase_d) begin
            if (state_d == RINGING) begin
                blank = 1'b1;
            end else if ((state_d == EDIT_TIME || state_d == EDIT_ALARM) &&
                         field_of_idx == IDX_W'(bus.edit_field)) begin
                blank = 1'b1;
            end
        end

        bcd_d    = frame_d[4*idx_d +: 4];
        anodes_d = blank ? '1 : ~(SEGMENT_NUM'(1) << idx_d);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pre_cnt  <= '0;
            idx_q    <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            state_q  <= SHOW_TIME;
            frame_q  <= '0;
            bcd_q    <= '0;
            anodes_q <= '1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            state_q <= state_d;
            frame_q <= frame_d;
            if (tick) begin
                bcd_q    <= bcd_d;
                anodes_q <= anodes_d;
            end
        end
    end

    assign bus.refresh_tick = tick;
    assign bus.digit_idx    = idx_q;
    assign bus.bcd_digit    = bcd_q;
    assign bus.anodes       = anodes_q;
endmodule
